// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared widths, types and FSM encoding for the Viterbi traceback controller
package viterbi_pkg;
   localparam int NUM_STATES = 8;
   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;
   typedef logic [NUM_STATES-1:0] surv_t;
   typedef enum logic [1:0] {FILL = 2'd0, TRACE = 2'd1, EMIT = 2'd2} fsm_t;
endpackage

// File: rtl/viterbi_surv_mem.sv
// viterbi_surv_mem: DEPTH x 8 survivor store, synchronous write, asynchronous read, no reset
module viterbi_surv_mem
   import viterbi_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  surv_t         wdata,
   input  logic [AW-1:0] raddr,
   output surv_t         rdata
);
   surv_t mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/viterbi_tb_ctrl.sv
// viterbi_tb_ctrl: block traceback controller; buffers survivors, traces back from the best state,
// then streams decoded bits in forward order
module viterbi_tb_ctrl
   import viterbi_pkg::*;
#(
   parameter int TB_LEN = 16
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   in_valid,
   output logic   in_ready,
   input  surv_t  in_surv,
   input  state_t in_bstate,
   input  logic   in_last,
   output logic   out_valid,
   input  logic   out_ready,
   output logic   out_bit,
   output logic   out_last,
   output logic   busy
);
   localparam int AW = $clog2(TB_LEN);
   localparam int NW = AW + 1;
   fsm_t st, nxt;
   logic [NW-1:0] n;
   logic [AW-1:0] ptr, idx;
   state_t cur;
   logic frame_end;
   logic [TB_LEN-1:0] bit_buf;
   surv_t rdata;
   logic acc, close, at_end, fin;
   assign acc = in_ready & in_valid;
   assign close = acc & (in_last | (n == NW'(TB_LEN - 1)));
   assign at_end = {1'b0, idx} == n - 1'b1;
   assign fin = out_valid & out_ready & at_end;
   assign in_ready = st == FILL;
   assign out_valid = st == EMIT;
   assign busy = st != FILL;
   assign out_bit = out_valid & bit_buf[idx];
   assign out_last = out_valid & frame_end & at_end;
   viterbi_surv_mem #(.DEPTH(TB_LEN)) u_mem (
      .clk   (clk),
      .we    (acc),
      .waddr (n[AW-1:0]),
      .wdata (in_surv),
      .raddr (ptr),
      .rdata (rdata)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= FILL;
      else st <= nxt;
   always_comb begin
      nxt = st;
      case (st)
         FILL:    nxt = close ? TRACE : FILL;
         TRACE:   nxt = (ptr == '0) ? EMIT : TRACE;
         EMIT:    nxt = fin ? FILL : EMIT;
         default: nxt = FILL;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n <= '0;
         ptr <= '0;
         idx <= '0;
         cur <= '0;
         frame_end <= 1'b0;
         bit_buf <= '0;
      end else begin
         case (st)
            FILL: if (acc) begin
               n <= n + 1'b1;
               cur <= in_bstate;
               frame_end <= in_last;
               ptr <= n[AW-1:0];
            end
            TRACE: begin
               bit_buf[ptr] <= cur[2];
               cur <= {cur[1:0], rdata[cur]};
               ptr <= ptr - 1'b1;
               idx <= '0;
            end
            EMIT: if (out_ready) begin
               if (at_end) begin
                  n <= '0;
                  frame_end <= 1'b0;
               end else idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// tb_viterbi_tb_ctrl: directed and randomized checks against a block-level traceback model
module tb_viterbi_tb_ctrl;
   localparam int L = 4;
   logic clk = 0, rst_n = 0;
   logic in_valid = 0, in_last = 0, out_ready = 1;
   logic [7:0] in_surv = 0;
   logic [2:0] in_bstate = 0;
   logic in_ready, out_valid, out_bit, out_last, busy;
   int n_chk = 0, n_fail = 0;
   bit rnd = 0;
   bit got_b[$], got_l[$];
   viterbi_tb_ctrl #(.TB_LEN(L)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_surv(in_surv), .in_bstate(in_bstate), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
      .out_last(out_last), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Model: collect a block's steps, trace it back in one shot, then expect n trace cycles
   // followed by the bits in forward order, one per sink handshake.
   logic [7:0] q_s[$];
   bit exp_b[$], exp_l[$];
   bit m_busy = 0;
   int cyc = 0, emit_at = 0;
   always @(posedge clk or negedge rst_n) begin : model
      int pre, nb;
      logic [2:0] s;
      logic [7:0] v;
      bit tb[L];
      if (!rst_n) begin
         cyc = 0; m_busy = 0; q_s.delete(); exp_b.delete(); exp_l.delete();
      end else begin
         pre = cyc;
         cyc++;
         if (m_busy && pre >= emit_at) begin
            if (out_ready) begin
               void'(exp_b.pop_front());
               void'(exp_l.pop_front());
               if (exp_b.size() == 0) m_busy = 0;
            end
         end else if (!m_busy && in_valid) begin
            q_s.push_back(in_surv);
            if (q_s.size() == L || in_last) begin
               nb = q_s.size();
               s = in_bstate;
               for (int k = nb - 1; k >= 0; k--) begin
                  tb[k] = s[2];
                  v = q_s[k];
                  s = {s[1:0], v[s]};
               end
               for (int k = 0; k < nb; k++) begin
                  exp_b.push_back(tb[k]);
                  exp_l.push_back(in_last && k == nb - 1);
               end
               q_s.delete();
               m_busy = 1;
               emit_at = cyc + nb;
            end
         end
      end
   end
   always @(negedge clk) if (rst_n) begin : compare
      bit ev;
      ev = m_busy && cyc >= emit_at;
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, ev);
      if (ev && exp_b.size() > 0) begin
         chk("out_bit", out_bit, exp_b[0]);
         chk("out_last", out_last, exp_l[0]);
      end
      if (out_valid && out_ready) begin
         got_b.push_back(out_bit);
         got_l.push_back(out_last);
      end
   end
   always @(posedge clk) if (rnd) #1 out_ready = ($urandom_range(3) != 0);
   task automatic send(input logic [7:0] s, input logic [2:0] b, input logic l);
      int k = 0;
      in_valid = 1; in_surv = s; in_bstate = b; in_last = l;
      do begin @(negedge clk); k++; end while (!in_ready && k < 300);
      chk("send_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0; in_last = 0;
   endtask
   task automatic wait_idle();
      int k = 0;
      do begin @(negedge clk); k++; end while ((busy || !in_ready) && k < 300);
      chk("idle", {busy, in_ready}, 2'b01);
      @(posedge clk); #1;
   endtask
   task automatic chk_got(input string name, input int nb, input int bits, input int lasts);
      int pb = 0, pl = 0;
      chk({name, "_count"}, got_b.size(), nb);
      for (int i = 0; i < got_b.size() && i < 32; i++) begin
         pb[i] = got_b[i];
         pl[i] = got_l[i];
      end
      chk({name, "_bits"}, pb, bits);
      chk({name, "_lasts"}, pl, lasts);
      got_b.delete(); got_l.delete();
   endtask
   task automatic block4(input logic l);
      send(8'h00, 3'd0, 0);
      send(8'h00, 3'd0, 0);
      send(8'h00, 3'd0, 0);
      send(8'h40, 3'd6, l);
   endtask
   initial begin
      int tr;
      logic b0;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_bit", out_bit, 0);
      chk("rst_out_last", out_last, 0);
      #20 rst_n = 1;
      @(posedge clk); #1;
      // bits 1,0,1,1 packed first-bit-in-LSB
      block4(0); wait_idle(); chk_got("blk", 4, 4'b1101, 4'b0000);
      block4(1); wait_idle(); chk_got("blk_last", 4, 4'b1101, 4'b1000);
      send(8'h00, 3'd4, 0);
      send(8'h00, 3'd2, 1);
      tr = 0;
      repeat (2) begin @(negedge clk); if (busy && !out_valid) tr++; end
      chk("early_trace_cycles", tr, 2);
      @(negedge clk); chk("early_valid", out_valid, 1);
      wait_idle(); chk_got("early", 2, 2'b01, 2'b10);
      for (int i = 0; i < L; i++) send(8'($urandom), 3'($urandom), 0);
      tr = 0;
      do begin @(negedge clk); tr++; end while (!out_valid && tr < 100);
      chk("stall_reach_emit", out_valid, 1);
      @(posedge clk); #1 out_ready = 0;
      @(negedge clk); b0 = out_bit;
      repeat (4) begin
         @(negedge clk);
         chk("stall_bit", out_bit, b0);
         chk("stall_in_ready", in_ready, 0);
      end
      @(posedge clk); #1 out_ready = 1;
      wait_idle(); got_b.delete(); got_l.delete();
      block4(0);
      in_valid = 1; in_surv = 8'h40; in_bstate = 3'd6; in_last = 0;
      wait_idle();
      in_valid = 0;
      send(8'h00, 3'd0, 0);
      send(8'h00, 3'd0, 0);
      send(8'h40, 3'd6, 0);
      wait_idle(); got_b.delete(); got_l.delete();
      block4(0);
      @(negedge clk); #2 rst_n = 0;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk); #2 rst_n = 1;
      @(posedge clk); #1;
      got_b.delete(); got_l.delete();
      block4(0); wait_idle(); chk_got("post_rst", 4, 4'b1101, 4'b0000);
      rnd = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
         send(8'($urandom), 3'($urandom), $urandom_range(4) == 0);
      end
      wait_idle();
      rnd = 0;
      #2 out_ready = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1);
   end
endmodule

// File: doc/viterbi_tb_ctrl.md
# viterbi_tb_ctrl

Block-based traceback controller for the 8-state Viterbi decoder. Each trellis step it accepts the 8 survivor decision bits from the ACS array and the best state chosen by the decision unit. After a block of up to TB_LEN steps it traces back from the best state through the buffered survivors and emits decoded bits in forward order over a valid/ready stream. It sits between the ACS/decision stage and the decoded-bit sink, and stalls the trellis while it traces back and drains.

## Interface
- TB_LEN, 16: traceback/block depth in trellis steps; must be ≥2.
- clk in 1: single clock; all state updates on the rising edge.
- rst_n in 1: asynchronous, active-low reset.
- in_valid in 1: survivor vector and best state valid this cycle.
- in_ready out 1: block can accept a step. Reset value 1.
- in_surv in 8: in_surv[s] is the survivor bit for state s at this step.
- in_bstate in 3: minimum-metric state at this step.
- in_last in 1: this step closes the frame; forces the block to end here.
- out_valid out 1: out_bit is valid. Reset value 0.
- out_ready in 1: sink accepts out_bit.
- out_bit out 1: decoded bit. Reset value 0.
- out_last out 1: final bit of a block closed by in_last. Reset value 0.
- busy out 1: high in TRACE or EMIT. Reset value 0.

## Operation
- Trellis convention: the next state is {u, s[2:1]}. The predecessor of s is {s[1:0], surv}. The decoded bit for state s is s[2].
- FSM states are FILL, TRACE and EMIT. Reset enters FILL with step count n=0.
- FILL:
  - in_ready=1.
  - On an accepted step (in_valid & in_ready), in_surv is written to surv_mem[n] and n increments.
  - in_bstate and in_last of the accepted step are captured into cur_state and frame_end.
  - The block closes when n reaches TB_LEN or in_last=1, whichever comes first; both at once count as one close. The next state is then TRACE with ptr=n-1.
- TRACE:
  - in_ready=0. One step per cycle.
  - Each cycle: bit_buf[ptr] ← cur_state[2]; cur_state ← {cur_state[1:0], surv_mem[ptr][cur_state]}; ptr decrements.
  - After the ptr=0 step, the FSM moves to EMIT with idx=0.
- EMIT:
  - in_ready=0. out_valid=1 and out_bit=bit_buf[idx].
  - idx advances only when out_valid & out_ready.
  - out_last = frame_end & (idx==n-1).
  - After the idx=n-1 handshake, the FSM returns to FILL with n=0 and frame_end=0.
- Width rules:
  - n has width clog2(TB_LEN)+1.
  - ptr and idx have width clog2(TB_LEN).
  - cur_state is 3 bits; its wrap is implicit in the shift.
- Boundary conditions:
  - An in_last on the first step gives n=1: one TRACE cycle, then one output bit.
  - in_valid is ignored while in_ready=0; the upstream holds its data.
  - out_ready may stall indefinitely; out_bit and out_valid stay stable while stalled.
  - Reset asserted mid-block discards the buffered steps, returns to FILL and applies all reset values immediately.

## Timing
- Last step of a block is accepted at cycle t:
  - TRACE occupies cycles t+1 .. t+n.
  - out_valid first rises at t+n+1.
- With out_ready held high, the final bit is transferred at t+2n and in_ready returns at t+2n+1.
- Throughput for a full block with no sink stall: TB_LEN steps per 3·TB_LEN cycles.
- No combinational path exists from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Package viterbi_pkg holds:
  - NUM_STATES=8 and STATE_W=3;
  - a state_t typedef (3 bits);
  - a surv_t typedef (8 bits);
  - FSM encoding constants for FILL, TRACE and EMIT.
- Sub-module viterbi_surv_mem is the TB_LEN×8 survivor store. It has one synchronous write port and one asynchronous read port, and its contents are not reset.
- bit_buf is a TB_LEN-bit register inside the controller.

## Test plan
- TB_LEN=4, encoder input 1,0,1,1 from state 0:
  - Stimulus: in_surv steps = 0x00, 0x00, 0x00, 0x40; in_bstate=6 on the last step; in_last=0.
  - Required: outputs 1,0,1,1 and out_last=0.
- Same stimulus with in_last=1 on step 4: same bits, with out_last=1 on the fourth bit only.
- Early close:
  - Stimulus: TB_LEN=16; two steps (in_surv=0x00 with in_bstate=4, then in_surv=0x00 with in_bstate=2) with in_last on step 2.
  - Required: 2 TRACE cycles, then outputs 1,0, with out_last on the second bit.
- Backpressure and stall:
  - Stimulus: hold out_ready=0 for 5 cycles during EMIT.
  - Required: out_bit stable, idx stable, in_ready=0; draining resumes correctly when out_ready returns.
- in_valid held high through TRACE and EMIT: no extra step is written, and the next block starts with n=0.
- Reset mid-TRACE: rst_n low for 1 cycle. Required: immediately in_ready=1, out_valid=0, busy=0; a fresh 4-step block then decodes correctly.
